// File: rtl/uart_cmd_assembler.sv
`default_nettype none
// ============================================================================
// Module  : uart_cmd_assembler
// Brief   : Pairs UART bytes (high first) into 16-bit commands with timeout/overrun flags.
// Revision: 1.0
// ============================================================================
module uart_cmd_assembler #(
  parameter int TIMEOUT = 131072,
  parameter int TMR_W   = $clog2(TIMEOUT)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_rdy,
  output logic        clr_rx_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        to_err,
  output logic        cmd_ovr
);

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_WAIT_LO = 1'b1
  } state_t;

  localparam logic [TMR_W-1:0] C_TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_hi_byte;
  logic [TMR_W-1:0]  r_timer;
  logic [15:0]       r_cmd;
  logic              r_cmd_rdy;
  logic              r_to_err;
  logic              r_cmd_ovr;
  logic              w_consume;
  logic              w_complete;
  logic              w_timeout;

  always_comb begin
    w_state_nxt = r_state;
    w_consume   = 1'b0;
    w_complete  = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rx_rdy) begin
          w_consume   = 1'b1;
          w_state_nxt = S_WAIT_LO;
        end
      end
      S_WAIT_LO: begin
        // A byte arriving on the timeout cycle takes precedence over the timeout.
        if (rx_rdy) begin
          w_consume   = 1'b1;
          w_complete  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_timer == C_TMR_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_hi_byte <= 8'h00;
      r_timer   <= '0;
      r_cmd     <= 16'h0000;
      r_cmd_rdy <= 1'b0;
      r_to_err  <= 1'b0;
      r_cmd_ovr <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_to_err <= w_timeout;
      // Timer only runs while staying in WAIT_LO; it reads zero everywhere else.
      if (r_state == S_WAIT_LO && w_state_nxt == S_WAIT_LO) begin
        r_timer <= r_timer + 1'b1;
      end else begin
        r_timer <= '0;
      end
      if (r_state == S_IDLE && rx_rdy) begin
        r_hi_byte <= rx_data;
      end else if (w_timeout) begin
        r_hi_byte <= 8'h00;
      end
      if (w_complete) begin
        r_cmd     <= {r_hi_byte, rx_data};
        r_cmd_rdy <= 1'b1;
        if (r_cmd_rdy && !clr_cmd_rdy) begin
          r_cmd_ovr <= 1'b1;
        end
      end else if (clr_cmd_rdy) begin
        r_cmd_rdy <= 1'b0;
      end
    end
  end

  assign clr_rx_rdy = w_consume;
  assign cmd        = r_cmd;
  assign cmd_rdy    = r_cmd_rdy;
  assign to_err     = r_to_err;
  assign cmd_ovr    = r_cmd_ovr;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_assembler.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_cmd_assembler
// Brief   : Directed self-checking bench for uart_cmd_assembler (TIMEOUT=64).
// Revision: 1.0
// ============================================================================
module tb_uart_cmd_assembler;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_rdy;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        to_err;
  logic        cmd_ovr;

  int n_tests = 0;
  int n_fail  = 0;
  int clr_cnt = 0;
  int to_cnt  = 0;

  uart_cmd_assembler #(.TIMEOUT(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_rdy      (rx_rdy),
    .clr_rx_rdy  (clr_rx_rdy),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .to_err      (to_err),
    .cmd_ovr     (cmd_ovr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (clr_rx_rdy) clr_cnt++;
    if (to_err) to_cnt++;
  end

  // Receiver model: byte presented at negedge, dropped just after the consuming edge.
  task automatic send_byte(input logic [7:0] b, input logic ack);
    @(negedge clk);
    rx_data     = b;
    rx_rdy      = 1'b1;
    clr_cmd_rdy = ack;
    #1;
    n_tests++;
    if (clr_rx_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL consume_strobe byte=%h got=%b exp=1", b, clr_rx_rdy);
    end
    @(posedge clk);
    #1;
    rx_rdy      = 1'b0;
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic ack_cmd();
    @(negedge clk);
    clr_cmd_rdy = 1'b1;
    @(posedge clk);
    #1;
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++;
    if ({cmd, cmd_rdy, to_err, cmd_ovr, clr_rx_rdy} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_state got cmd=%h rdy=%b to=%b ovr=%b clr=%b exp all 0",
               cmd, cmd_rdy, to_err, cmd_ovr, clr_rx_rdy);
    end
  endtask

  task automatic test_normal();
    send_byte(8'hA5, 1'b0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (cmd_rdy !== 1'b0 || clr_rx_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL normal_midwait got rdy=%b clr=%b exp 0 0", cmd_rdy, clr_rx_rdy);
    end
    send_byte(8'h3C, 1'b0);
    @(negedge clk);
    n_tests++;
    if (cmd !== 16'hA53C || cmd_rdy !== 1'b1 || to_err !== 1'b0 || cmd_ovr !== 1'b0) begin
      n_fail++;
      $display("FAIL normal_cmd got cmd=%h rdy=%b to=%b ovr=%b exp A53C 1 0 0",
               cmd, cmd_rdy, to_err, cmd_ovr);
    end
    n_tests++;
    if (clr_cnt !== 2) begin
      n_fail++;
      $display("FAIL normal_clr_count got=%0d exp=2", clr_cnt);
    end
  endtask

  task automatic test_handshake();
    repeat (100) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (cmd_rdy !== 1'b1 || cmd !== 16'hA53C) begin
      n_fail++;
      $display("FAIL handshake_hold got rdy=%b cmd=%h exp 1 A53C", cmd_rdy, cmd);
    end
    ack_cmd();
    n_tests++;
    if (cmd_rdy !== 1'b0 || cmd !== 16'hA53C) begin
      n_fail++;
      $display("FAIL handshake_clear got rdy=%b cmd=%h exp 0 A53C", cmd_rdy, cmd);
    end
  endtask

  task automatic test_timeout();
    int seen;
    seen = 0;
    send_byte(8'h11, 1'b0);
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (to_err === 1'b1) begin
        seen = i;
        break;
      end
    end
    n_tests++;
    if (seen !== 64) begin
      n_fail++;
      $display("FAIL timeout_latency got=%0d cycles exp=64 (0 = never)", seen);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (to_err !== 1'b0 || cmd_rdy !== 1'b0 || cmd !== 16'hA53C) begin
      n_fail++;
      $display("FAIL timeout_after got to=%b rdy=%b cmd=%h exp 0 0 A53C", to_err, cmd_rdy, cmd);
    end
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    @(negedge clk);
    n_tests++;
    if (cmd !== 16'h2233 || cmd_rdy !== 1'b1 || cmd_ovr !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_recover got cmd=%h rdy=%b ovr=%b exp 2233 1 0", cmd, cmd_rdy, cmd_ovr);
    end
    ack_cmd();
  endtask

  task automatic test_timeout_race();
    send_byte(8'h66, 1'b0);
    repeat (63) @(posedge clk);
    send_byte(8'h77, 1'b0);
    @(negedge clk);
    n_tests++;
    if (cmd !== 16'h6677 || cmd_rdy !== 1'b1 || to_cnt !== 1) begin
      n_fail++;
      $display("FAIL timeout_race got cmd=%h rdy=%b to_pulses=%0d exp 6677 1 1",
               cmd, cmd_rdy, to_cnt);
    end
    ack_cmd();
  endtask

  task automatic test_overrun();
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    @(negedge clk);
    n_tests++;
    if (cmd !== 16'h1234 || cmd_rdy !== 1'b1 || cmd_ovr !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_first got cmd=%h rdy=%b ovr=%b exp 1234 1 0", cmd, cmd_rdy, cmd_ovr);
    end
    send_byte(8'h56, 1'b0);
    send_byte(8'h78, 1'b0);
    @(negedge clk);
    n_tests++;
    if (cmd !== 16'h5678 || cmd_rdy !== 1'b1 || cmd_ovr !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_set got cmd=%h rdy=%b ovr=%b exp 5678 1 1", cmd, cmd_rdy, cmd_ovr);
    end
    send_byte(8'h9A, 1'b0);
    send_byte(8'hBC, 1'b1);
    @(negedge clk);
    n_tests++;
    if (cmd !== 16'h9ABC || cmd_rdy !== 1'b1 || cmd_ovr !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_coincident got cmd=%h rdy=%b ovr=%b exp 9ABC 1 1", cmd, cmd_rdy, cmd_ovr);
    end
  endtask

  task automatic test_reset_midcmd();
    send_byte(8'hF0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if ({cmd, cmd_rdy, to_err, cmd_ovr, clr_rx_rdy} !== 20'h0) begin
        n_fail++;
        $display("FAIL midreset_outputs cyc=%0d got cmd=%h rdy=%b to=%b ovr=%b exp all 0",
                 i, cmd, cmd_rdy, to_err, cmd_ovr);
      end
      @(negedge clk);
    end
    rst = 1'b0;
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    @(negedge clk);
    n_tests++;
    if (cmd !== 16'h0102 || cmd_rdy !== 1'b1 || cmd_ovr !== 1'b0 || to_err !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_after got cmd=%h rdy=%b ovr=%b to=%b exp 0102 1 0 0",
               cmd, cmd_rdy, cmd_ovr, to_err);
    end
    n_tests++;
    if (to_cnt !== 1) begin
      n_fail++;
      $display("FAIL to_err_total got=%0d exp=1", to_cnt);
    end
  endtask

  initial begin
    rst         = 1'b1;
    rx_data     = 8'h00;
    rx_rdy      = 1'b0;
    clr_cmd_rdy = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_normal();
    test_handshake();
    test_timeout();
    test_timeout_race();
    test_overrun();
    test_reset_midcmd();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_cmd_assembler.md
Name: uart_cmd_assembler

Overview:
- Sits between the UART receiver and the command dispatcher.
- Consumes received bytes through the receiver's rdy/clr_rdy handshake and assembles 16-bit commands from byte pairs, high byte first.
- Presents each complete command to the dispatcher with its own ready/clear handshake.
- Guards against a lost byte with an inter-byte timeout and flags commands overwritten before the consumer took them.

Parameters:
- TIMEOUT, 131072, clocks allowed in WAIT_LO between the high byte being consumed and the low byte arriving. Default is about 5 byte times at 50 MHz / 19200 baud. Legal range 2 .. 2^24.
- TMR_W, $clog2(TIMEOUT), width of the inter-byte timer.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- rx_data  input  8  byte from UART receiver; valid while rx_rdy=1
- rx_rdy  input  1  UART receiver holds a byte
- clr_rx_rdy  output  1  consume strobe to the UART receiver's clr_rdy (combinational)
- cmd  output  16  assembled command {high byte, low byte}
- cmd_rdy  output  1  cmd holds an unconsumed command
- clr_cmd_rdy  input  1  consumer acknowledge
- to_err  output  1  one-cycle pulse: inter-byte timeout, high byte dropped
- cmd_ovr  output  1  sticky: a command completed while cmd_rdy was still 1

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, hi_byte=0, cmd=16'h0000, cmd_rdy=0, to_err=0, cmd_ovr=0, timer=0.
  - Reset mid-command discards any held high byte. Nothing is emitted.
- FSM states: IDLE (waiting for high byte) and WAIT_LO (high byte held, waiting for low byte).
- IDLE:
  - If rx_rdy=1: clr_rx_rdy=1 in that same cycle, hi_byte<=rx_data, timer<=0, next state WAIT_LO.
  - Otherwise clr_rx_rdy=0 and timer holds 0.
- WAIT_LO, rx_rdy=1:
  - clr_rx_rdy=1 in that cycle.
  - cmd<={hi_byte, rx_data}, cmd_rdy<=1 at the same edge, next state IDLE.
  - Latency: cmd/cmd_rdy are visible the cycle after the low byte is consumed.
- WAIT_LO, rx_rdy=0:
  - timer<=timer+1.
  - When timer==TIMEOUT-1 (and rx_rdy=0): next state IDLE, to_err<=1 for exactly one cycle, hi_byte discarded, cmd/cmd_rdy unchanged.
  - If rx_rdy=1 on the timeout cycle, the byte wins: normal completion, no to_err.
- clr_rx_rdy:
  - Asserted only in cycles where the FSM consumes a byte; purely combinational from state and rx_rdy.
  - The receiver deasserts rdy at the next edge, so each byte is consumed exactly once. There is no consumption in the cycle after a consume because the state has changed and rx_rdy has dropped.
- cmd_rdy priority: completion sets > clr_cmd_rdy clears > hold.
  - Simultaneous completion and clr_cmd_rdy: cmd_rdy stays 1 with the new cmd.
- cmd is stable while cmd_rdy=1 except on overrun.
- Overrun:
  - A completion while cmd_rdy=1 and clr_cmd_rdy=0 overwrites cmd and sets cmd_ovr=1.
  - cmd_ovr clears only on rst.
- The receiver's rdy is never left pending more than one cycle in IDLE or WAIT_LO. Bytes are always drained, even if the consumer is stalled.

Test Plan:
- Normal command: after reset, send byte 8'hA5, wait 20 cycles, send 8'h3C -> clr_rx_rdy pulses once per byte; cmd=16'hA53C and cmd_rdy=1 one cycle after second consume; to_err=0, cmd_ovr=0.
- Consumer handshake: with cmd_rdy=1 hold 100 cycles, then pulse clr_cmd_rdy -> cmd_rdy=0 next cycle; cmd stays 16'hA53C.
- Timeout (TIMEOUT=64): send 8'h11, no further byte -> to_err high exactly one cycle, 64 cycles after the consume; state IDLE. Then send 8'h22, 8'h33 -> cmd=16'h2233 (8'h11 lost).
- Timeout race (TIMEOUT=64): present low byte 8'h77 on exactly the timeout cycle after high 8'h66 -> cmd=16'h6677, cmd_rdy=1, to_err never asserted.
- Overrun: complete 16'h1234, leave cmd_rdy set, complete 16'h5678 -> cmd=16'h5678, cmd_ovr=1 sticky. Completing again with clr_cmd_rdy coincident -> cmd_rdy stays 1 with the new value.
- Reset mid-command: send 8'hF0, assert rst 3 cycles, then send 8'h01, 8'h02 -> all outputs 0 during reset; cmd=16'h0102 afterward; cmd_ovr=0.
